// File: rtl/ppu_line_buf_pkg.sv
// Shared types and constants for the PPU-to-VGA ping-pong scanline buffer.
package ppu_line_buf_pkg;

    typedef enum logic {
        LB_RD_WAIT = 1'b0,
        LB_RD_SHOW = 1'b1
    } lb_rd_states_t;

    localparam logic [5:0] LB_BLANK_COLOR = 6'h0F;
    localparam int         LB_LINE_W      = 256;

endpackage

// File: rtl/ppu_line_buf_if.sv
// Write-side (PPU) and read-side (VGA) signals of the scanline buffer.
interface ppu_line_buf_if;

    logic       ppu_clk_en;
    logic       pix_valid;
    logic [7:0] pix_x;
    logic [5:0] pix_data;
    logic       ppu_line_done;
    logic       frame_sync;
    logic       vga_clk_en;
    logic [7:0] vga_buf_idx;
    logic       vga_line_done;
    logic [5:0] vga_buf_out;
    logic       overrun;
    logic       underrun;

    modport master (
        output ppu_clk_en, pix_valid, pix_x, pix_data, ppu_line_done, frame_sync,
        output vga_clk_en, vga_buf_idx, vga_line_done,
        input  vga_buf_out, overrun, underrun
    );

    modport slave (
        input  ppu_clk_en, pix_valid, pix_x, pix_data, ppu_line_done, frame_sync,
        input  vga_clk_en, vga_buf_idx, vga_line_done,
        output vga_buf_out, overrun, underrun
    );

endinterface

// File: rtl/ppu_line_buf_ram.sv
// One 256x6 scanline bank: synchronous write port, asynchronous read port.
module lb_bank_ram
    import ppu_line_buf_pkg::*;
(
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [5:0] wdata,
    input  logic [7:0] raddr,
    output logic [5:0] rdata
);

    logic [5:0] mem [LB_LINE_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ppu_line_buf.sv
// Two-bank ping-pong line buffer; each PPU line is shown REPEAT times on VGA.
// Optional macro LINEBUF_BLANK_ON_UNDERRUN_EN blanks the output while waiting.
module ppu_line_buf
    import ppu_line_buf_pkg::*;
#(
    parameter int REPEAT = 2
) (
    input logic           clk,
    input logic           rst,
    ppu_line_buf_if.slave bus
);

    localparam logic [1:0] REP_LAST = 2'(REPEAT - 1);

    logic [1:0]    full;
    logic          wr_bank;
    logic          rd_bank;
    logic [1:0]    rep_cnt;
    lb_rd_states_t state;
    logic          overrun;
    logic          underrun;

    logic [5:0] rd_data0;
    logic [5:0] rd_data1;
    logic [5:0] rd_data;

    lb_bank_ram bank0 (
        .clk   (clk),
        .we    (bus.ppu_clk_en && bus.pix_valid && !wr_bank),
        .waddr (bus.pix_x),
        .wdata (bus.pix_data),
        .raddr (bus.vga_buf_idx),
        .rdata (rd_data0)
    );

    lb_bank_ram bank1 (
        .clk   (clk),
        .we    (bus.ppu_clk_en && bus.pix_valid && wr_bank),
        .waddr (bus.pix_x),
        .wdata (bus.pix_data),
        .raddr (bus.vga_buf_idx),
        .rdata (rd_data1)
    );

    assign rd_data = rd_bank ? rd_data1 : rd_data0;

`ifdef LINEBUF_BLANK_ON_UNDERRUN_EN
    assign bus.vga_buf_out = (state == LB_RD_WAIT) ? LB_BLANK_COLOR : rd_data;
`else
    assign bus.vga_buf_out = rd_data;
`endif

    assign bus.overrun  = overrun;
    assign bus.underrun = underrun;

    logic          ppu_ev;
    logic          vga_ev;
    logic          last_rep;
    logic [1:0]    full_rel;
    logic [1:0]    full_nxt;
    logic          wr_nxt;
    logic          rd_nxt;
    logic [1:0]    rep_nxt;
    lb_rd_states_t state_nxt;
    logic          ovr_set;
    logic          und_set;

    // Same-edge ordering: reader release, then writer set, then reader selection.
    always_comb begin
        ppu_ev    = bus.ppu_line_done && bus.ppu_clk_en;
        vga_ev    = bus.vga_line_done && bus.vga_clk_en;
        last_rep  = (rep_cnt == REP_LAST);

        full_rel  = full;
        if (vga_ev && (state == LB_RD_SHOW) && last_rep) begin
            full_rel[rd_bank] = 1'b0;
        end

        full_nxt  = full_rel;
        wr_nxt    = wr_bank;
        ovr_set   = 1'b0;
        if (ppu_ev) begin
            full_nxt[wr_bank] = 1'b1;
            if (!full_rel[~wr_bank]) begin
                wr_nxt = ~wr_bank;
            end else begin
                ovr_set = 1'b1;
            end
        end

        rd_nxt    = rd_bank;
        rep_nxt   = rep_cnt;
        state_nxt = state;
        und_set   = 1'b0;
        if (vga_ev) begin
            case (state)
                LB_RD_WAIT: begin
                    if (full_nxt[~rd_bank]) begin
                        rd_nxt    = ~rd_bank;
                        state_nxt = LB_RD_SHOW;
                        rep_nxt   = 2'd0;
                    end else if (full_nxt[rd_bank]) begin
                        state_nxt = LB_RD_SHOW;
                        rep_nxt   = 2'd0;
                    end else begin
                        und_set = 1'b1;
                    end
                end
                LB_RD_SHOW: begin
                    if (last_rep) begin
                        rep_nxt = 2'd0;
                        if (full_nxt[~rd_bank]) begin
                            rd_nxt = ~rd_bank;
                        end else begin
                            state_nxt = LB_RD_WAIT;
                        end
                    end else begin
                        rep_nxt = rep_cnt + 2'd1;
                    end
                end
                default: state_nxt = LB_RD_WAIT;
            endcase
        end
    end

    // frame_sync realigns both sides but leaves memory and sticky flags alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            full     <= 2'b00;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            rep_cnt  <= 2'd0;
            state    <= LB_RD_WAIT;
            overrun  <= 1'b0;
            underrun <= 1'b0;
        end else if (bus.frame_sync) begin
            full     <= 2'b00;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            rep_cnt  <= 2'd0;
            state    <= LB_RD_WAIT;
        end else begin
            full     <= full_nxt;
            wr_bank  <= wr_nxt;
            rd_bank  <= rd_nxt;
            rep_cnt  <= rep_nxt;
            state    <= state_nxt;
            if (ovr_set) begin
                overrun <= 1'b1;
            end
            if (und_set) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule
